shc_error_recovery: RTL and testbench
=====================================

// Module: shc_error_recovery
// PURPOSE
//  Consumer end of the speculative Han-Carlson carry path. Registers one operand pair, forms the
//  windowed (speculative) sum, detects a mis-speculated carry and, only then, spends one extra cycle
//  producing the exact sum. Result always exact; latency 1 or 2 cycles. Sits between operand
//  source and any downstream datapath needing a valid/ready adder with speculative fast path.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits
//  WINDOW  8   carry-speculation span; carry into bit i sees only bits [max(0,i-WINDOW), i-1]
//  CNT_W   16  width of the saturating correction counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  exact a+b+cin, low WIDTH bits
//  cout       out  1      exact carry out
//  corrected  out  1      1 = result needed the correction cycle
//  corr_count out  CNT_W  number of corrections since reset, saturating
// BEHAVIOUR
//  One clock (clk); reset is synchronous and active-high (rst); all state updates on posedge clk.
//  Reset: state=IDLE; out_valid=0, sum=0, cout=0, corrected=0, corr_count=0. in_ready=1 after reset.
//  p=a^b, g=a&b on latched operands. Speculative carry into bit i = group-generate of span
//   [max(0,i-WINDOW), i-1]; cin included only when i<=WINDOW. spec_cout = speculative carry into bit WIDTH.
//  err = ({spec_cout,spec_sum} != exact {cout,sum}); equivalently some span of WINDOW consecutive
//   propagates whose lower neighbour carries 1. Either implementation acceptable; must match bit-exactly.
//  FSM (3 states):
//   IDLE : in_ready=1, out_valid=0. in_valid -> latch a,b,cin; err=0 -> OUT with spec result,
//          corrected=0; err=1 -> FIX.
//   FIX  : one cycle; in_ready=0, out_valid=0; load exact sum/cout, corrected=1,
//          corr_count+=1 unless all-ones -> OUT.
//   OUT  : out_valid=1; sum/cout/corrected held stable while out_ready=0, in_ready=0.
//          out_ready=1 -> result retired; in_ready=1 same cycle; if in_valid also 1 the new pair is
//          latched (-> OUT or FIX per err), else -> IDLE.
//  Latency accept->out_valid: 1 cycle (no error), 2 cycles (error). Peak throughput 1 result/cycle.
//  in_ready = (state==IDLE) | (state==OUT & out_ready). Operands ignored while in_ready=0.
//  Width: internal sum WIDTH+1 bits; cout = bit WIDTH. No overflow flag; unsigned wrap.
//  corr_count saturates at 2^CNT_W-1, never wraps. Cleared only by rst.
//  rst in any state (incl. FIX, or OUT with out_ready=0) drops the in-flight transaction, no output.
//  WINDOW>=WIDTH: err never asserts; FIX unreachable.
// TESTING (WIDTH=16, WINDOW=8 unless stated)
//  1. a=0x0001,b=0x0002,cin=0 accepted cycle t -> out_valid at t+1, sum=0x0003,cout=0,corrected=0,count=0.
//  2. a=0x7FFF,b=0x0001,cin=0 -> out_valid at t+2, sum=0x8000,cout=0,corrected=1,corr_count=1.
//  3. a=0xFFFF,b=0x0000,cin=1 -> sum=0x0000,cout=1,corrected=1; a=0xFFFF,b=0xFFFF,cin=0 -> 0xFFFE,cout=1,corrected=0.
//  4. Back-to-back valid with out_ready=1 on 8 no-error pairs -> one result/cycle, in order, no drops;
//     out_ready=0 for 3 cycles -> sum/cout stable, in_ready=0, new operands not latched.
//  5. CNT_W=2, five error pairs (case 2) -> corr_count 1,2,3,3,3.
//  6. rst=1 during FIX of case 2 -> next cycle out_valid=0, in_ready=1, corr_count=0; no stale result later.

Source files
------------

// File: rtl/shc_error_recovery_if.sv
// Operand/result handshake bundle for the speculative-adder recovery stage.
// slave is the adder side, master is the operand source / result sink.
interface shc_error_recovery_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             corrected;
    logic [CNT_W-1:0] corr_count;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, corrected, corr_count
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, corrected, corr_count
    );
endinterface

// File: rtl/shc_error_recovery.sv
// Speculative (windowed-carry) adder with one-cycle error recovery.
// Accepted pairs whose windowed sum is already exact are returned next cycle; otherwise a
// FIX cycle recomputes the exact sum from the latched operands.
module shc_error_recovery #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    shc_error_recovery_if.slave  bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFix  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    localparam int Wd  = int'(WIDTH);
    localparam int Win = int'(WINDOW);

    // Windowed sum: carry into bit i only sees bits [max(0,i-WINDOW), i-1]; cin only when the
    // window reaches bit 0. Bit WIDTH of the result is the speculative carry out.
    function automatic logic [WIDTH:0] spec_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             c0);
        logic [WIDTH:0] res;
        logic           c;
        res = '0;
        for (int i = 0; i <= Wd; i++) begin
            c = (i <= Win) ? c0 : 1'b0;
            for (int j = 0; j < Wd; j++) begin
                if (j < i && j + Win >= i) begin
                    c = (x[j] & y[j]) | ((x[j] ^ y[j]) & c);
                end
            end
            if (i < Wd) begin
                res[i] = x[i] ^ y[i] ^ c;
            end else begin
                res[i] = c;
            end
        end
        return res;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             corrected_q, corrected_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   spec_in;
    logic [WIDTH:0]   exact_in;
    logic [WIDTH:0]   exact_fix;
    logic             err;
    logic             in_ready;
    logic             accept;

    assign spec_in   = spec_add(bus.a, bus.b, bus.cin);
    assign exact_in  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
    assign exact_fix = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    assign err       = (spec_in != exact_in);

    assign in_ready = (state_q == StIdle) | ((state_q == StOut) & bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    // Next-state and datapath loads: FIX repairs the result, accept launches a new pair.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        corrected_d = corrected_q;
        cnt_d       = cnt_q;

        case (state_q)
            StIdle: state_d = StIdle;
            StOut: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            StFix: begin
                sum_d       = exact_fix[WIDTH-1:0];
                cout_d      = exact_fix[WIDTH];
                corrected_d = 1'b1;
                if (~&cnt_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                state_d = StOut;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            cin_d = bus.cin;
            if (err) begin
                state_d = StFix;
            end else begin
                state_d     = StOut;
                sum_d       = spec_in[WIDTH-1:0];
                cout_d      = spec_in[WIDTH];
                corrected_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; reset drops any in-flight pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            corrected_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            corrected_q <= corrected_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == StOut);
    assign bus.sum        = sum_q;
    assign bus.cout       = cout_q;
    assign bus.corrected  = corrected_q;
    assign bus.corr_count = cnt_q;

endmodule

// File: tb/tb_shc_error_recovery.sv
// Randomized + directed bench for shc_error_recovery. Two instances share stimulus: one with a
// 16-bit correction counter, one with a 2-bit counter to exercise saturation.
module tb_shc_error_recovery;

    localparam int W   = 16;
    localparam int WIN = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    shc_error_recovery_if #(.WIDTH(16), .CNT_W(16)) bus1 ();
    shc_error_recovery_if #(.WIDTH(16), .CNT_W(2))  bus2 ();

    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.a         = bus1.a;
    assign bus2.b         = bus1.b;
    assign bus2.cin       = bus1.cin;
    assign bus2.out_ready = bus1.out_ready;

    shc_error_recovery #(.WIDTH(16), .WINDOW(8), .CNT_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    shc_error_recovery #(.WIDTH(16), .WINDOW(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: exact sum by plain addition.
    function automatic logic [16:0] model_exact(input logic [15:0] a, input logic [15:0] b,
                                                input logic c);
        return 17'(a) + 17'(b) + 17'(c);
    endfunction

    // Reference: each speculative carry is the overflow of adding only the window's bit slices.
    function automatic logic [16:0] model_spec(input logic [15:0] a, input logic [15:0] b,
                                               input logic c);
        logic [16:0]     r;
        longint unsigned av;
        longint unsigned bv;
        av = 64'(a);
        bv = 64'(b);
        r  = '0;
        for (int i = 0; i <= W; i++) begin
            int              lo;
            int              n;
            longint unsigned m;
            longint unsigned s;
            logic            ci;
            lo = (i > WIN) ? i - WIN : 0;
            n  = i - lo;
            m  = (64'd1 << n) - 64'd1;
            s  = ((av >> lo) & m) + ((bv >> lo) & m) + ((lo == 0) ? 64'(c) : 64'd0);
            ci = ((s >> n) & 64'd1) != 0;
            if (i < W) r[i] = a[i] ^ b[i] ^ ci;
            else       r[i] = ci;
        end
        return r;
    endfunction

    function automatic bit model_err(input logic [15:0] a, input logic [15:0] b, input logic c);
        return model_spec(a, b, c) != model_exact(a, b, c);
    endfunction

    typedef struct {
        logic [16:0] res;
        logic        corr;
        int          cnt16;
        int          cnt2;
        int          t;
        bit          seen;
    } exp_t;

    exp_t q[$];
    int   m_cnt16 = 0;
    int   m_cnt2  = 0;

    // Scoreboard: inputs change #1 after posedge, so negedge sees what the next posedge samples.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else begin
            if (q.size() == 0) begin
                check_val("idle_out_valid", bus1.out_valid, 0);
                check_val("idle_in_ready", bus1.in_ready, 1);
            end else begin
                if (!bus1.out_ready) check_val("stall_in_ready", bus1.in_ready, 0);
                if (!q[0].seen && q[0].corr && (cyc - q[0].t) == 1)
                    check_val("fix_in_ready", bus1.in_ready, 0);
                if (bus1.out_valid) begin
                    if (!q[0].seen) check_val("latency", cyc - q[0].t, q[0].corr ? 2 : 1);
                    q[0].seen = 1'b1;
                    check_val("sum", bus1.sum, q[0].res[15:0]);
                    check_val("cout", bus1.cout, q[0].res[16]);
                    check_val("corrected", bus1.corrected, q[0].corr);
                    check_val("corr_count", bus1.corr_count, q[0].cnt16);
                    check_val("sum_w2", bus2.sum, q[0].res[15:0]);
                    check_val("corr_count_w2", bus2.corr_count, q[0].cnt2);
                    if (bus1.out_ready) void'(q.pop_front());
                end else if (cyc - q[0].t > 2) begin
                    check_val("out_timeout", cyc - q[0].t, 2);
                    void'(q.pop_front());
                end
            end
            if (bus1.in_valid && bus1.in_ready) begin
                exp_t e;
                e.res  = model_exact(bus1.a, bus1.b, bus1.cin);
                e.corr = model_err(bus1.a, bus1.b, bus1.cin);
                if (e.corr) begin
                    if (m_cnt16 < 65535) m_cnt16++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
                e.cnt16 = m_cnt16;
                e.cnt2  = m_cnt2;
                e.t     = cyc;
                e.seen  = 1'b0;
                q.push_back(e);
            end
        end
    end

    // Present one pair until accepted (bounded); returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.a        = a;
        bus1.b        = b;
        bus1.cin      = c;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus1.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus1.in_valid = 1'b0;
        if (!acc) check_val("send_timeout", 0, 1);
    endtask

    // Wait (bounded) for out_valid; returns at the negedge where it is seen.
    task automatic wait_out();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus1.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.out_valid) check_val("wait_out_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int          exp5[5];
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] last_res;

        exp5 = '{1, 2, 3, 3, 3};
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.cin       = 1'b0;
        bus1.out_ready = 1'b1;
        last_res       = '0;

        do_reset();
        @(negedge clk);
        check_val("rst_out_valid", bus1.out_valid, 0);
        check_val("rst_in_ready", bus1.in_ready, 1);
        check_val("rst_sum", bus1.sum, 0);
        check_val("rst_cout", bus1.cout, 0);
        check_val("rst_corrected", bus1.corrected, 0);
        check_val("rst_count", bus1.corr_count, 0);
        @(posedge clk);
        #1;

        // Fast path and correction path with known constants.
        send(16'h0001, 16'h0002, 1'b0);
        wait_out();
        check_val("t1_sum", bus1.sum, 16'h0003);
        check_val("t1_corrected", bus1.corrected, 0);
        check_val("t1_count", bus1.corr_count, 0);
        @(posedge clk);
        #1;
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_out();
        check_val("t2_sum", bus1.sum, 16'h8000);
        check_val("t2_cout", bus1.cout, 0);
        check_val("t2_corrected", bus1.corrected, 1);
        check_val("t2_count", bus1.corr_count, 1);
        @(posedge clk);
        #1;
        send(16'hFFFF, 16'h0000, 1'b1);
        wait_out();
        check_val("t3a_sum", bus1.sum, 16'h0000);
        check_val("t3a_cout", bus1.cout, 1);
        check_val("t3a_corrected", bus1.corrected, 1);
        @(posedge clk);
        #1;
        send(16'hFFFF, 16'hFFFF, 1'b0);
        wait_out();
        check_val("t3b_sum", bus1.sum, 16'hFFFE);
        check_val("t3b_cout", bus1.cout, 1);
        check_val("t3b_corrected", bus1.corrected, 0);
        @(posedge clk);
        #1;

        // Back-to-back no-error pairs, then a 3-cycle stall with junk operands offered.
        for (int k = 0; k < 8; k++) begin
            int tries;
            tries = 0;
            do begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                tries++;
            end while (model_err(ra, rb, rc) && tries < 100);
            if (model_err(ra, rb, rc)) begin
                ra = 16'h0001;
                rb = 16'h0002;
                rc = 1'b0;
            end
            last_res      = model_exact(ra, rb, rc);
            bus1.in_valid = 1'b1;
            bus1.a        = ra;
            bus1.b        = rb;
            bus1.cin      = rc;
            @(negedge clk);
            check_val("b2b_in_ready", bus1.in_ready, 1);
            check_val("b2b_out_valid", bus1.out_valid, (k > 0) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        bus1.a         = 16'h7FFF;
        bus1.b         = 16'h0001;
        bus1.cin       = 1'b0;
        bus1.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check_val("stall_out_valid", bus1.out_valid, 1);
            check_val("stall_sum", bus1.sum, last_res[15:0]);
            check_val("stall_cout", bus1.cout, last_res[16]);
            check_val("stall_ready", bus1.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Saturation of the 2-bit counter.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(16'h7FFF, 16'h0001, 1'b0);
            wait_out();
            check_val("sat_count_w2", bus2.corr_count, exp5[k]);
            @(posedge clk);
            #1;
        end

        // Reset during FIX drops the transaction.
        send(16'h7FFF, 16'h0001, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rstfix_out_valid", bus1.out_valid, 0);
        check_val("rstfix_in_ready", bus1.in_ready, 1);
        check_val("rstfix_count", bus1.corr_count, 0);
        check_val("rstfix_count_w2", bus2.corr_count, 0);
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and occasional reset.
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus1.in_valid  = ($urandom_range(0, 3) != 0);
            bus1.out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: begin
                    bus1.a = 16'($urandom);
                    bus1.b = 16'($urandom);
                end
                1: begin
                    bus1.a = 16'($urandom);
                    bus1.b = ~bus1.a ^ (16'd1 << $urandom_range(0, 15));
                end
                default: begin
                    bus1.a = 16'($urandom);
                    bus1.b = ~bus1.a;
                end
            endcase
            bus1.cin = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rst            = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_val("drain_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
